// File: rtl/keccak_word_serializer_if.sv
// Handshake bundle between a wide-word producer and keccak_word_serializer.
// The master drives load/flush/out_ready; the slave (the serializer) drives the narrow stream.
interface keccak_word_serializer_if #(
    parameter int IN_W  = 512,
    parameter int OUT_W = 32
);
    localparam int N  = IN_W / OUT_W;
    localparam int CW = $clog2(N) + 1;

    logic [IN_W-1:0]  in_data;
    logic [CW-1:0]    in_len;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic [CW-1:0]    out_idx;
    logic             busy;

    modport master (
        output in_data, in_len, in_valid, flush, out_ready,
        input  in_ready, out_data, out_valid, out_last, out_idx, busy
    );

    modport slave (
        input  in_data, in_len, in_valid, flush, out_ready,
        output in_ready, out_data, out_valid, out_last, out_idx, busy
    );
endinterface

// File: rtl/keccak_word_serializer.sv
// Captures one wide Keccak word and streams it out MS word first as OUT_W-bit beats.
// Optional build macro KECCAK_SER_BYTE_SWAP_EN adds swap_bytes (latched at load) to byte-reverse each word.
module keccak_word_serializer #(
    parameter int IN_W  = 512,
    parameter int OUT_W = 32
) (
    input logic clk,
    input logic reset,
`ifdef KECCAK_SER_BYTE_SWAP_EN
    input logic swap_bytes,
`endif
    keccak_word_serializer_if.slave bus
);
    localparam int N  = IN_W / OUT_W;
    localparam int CW = $clog2(N) + 1;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t           state;
    state_t           state_next;
    logic [IN_W-1:0]  shreg;
    logic [CW-1:0]    len_q;
    logic [CW-1:0]    idx_q;
    logic [CW-1:0]    len_eff;
    logic             last;
    logic             beat;
    logic             load;
    logic             in_ready_c;
    logic [OUT_W-1:0] word_raw;
`ifdef KECCAK_SER_BYTE_SWAP_EN
    logic             swap_q;
    logic [OUT_W-1:0] word_swapped;
`endif

    // A zero or oversized request means "the whole block".
    assign len_eff = (bus.in_len == '0 || bus.in_len > CW'(N)) ? CW'(N) : bus.in_len;

    assign last          = (state == STREAM) && (idx_q == len_q - CW'(1));
    assign beat          = (state == STREAM) && bus.out_ready;
    assign bus.out_valid = (state == STREAM);
    assign bus.busy      = (state == STREAM);
    assign bus.out_last  = last;
    assign bus.out_idx   = idx_q;
    assign bus.in_ready  = in_ready_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A load is accepted when idle, or on the final beat so the next block follows without a bubble.
    always_comb begin
        state_next = state;
        in_ready_c = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = !bus.flush;
                load       = bus.in_valid && in_ready_c;
                if (load) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                in_ready_c = !bus.flush && last && bus.out_ready;
                load       = bus.in_valid && in_ready_c;
                if (bus.flush) begin
                    state_next = IDLE;
                end else if (beat && last) begin
                    state_next = load ? STREAM : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg <= '0;
            len_q <= CW'(N);
            idx_q <= '0;
`ifdef KECCAK_SER_BYTE_SWAP_EN
            swap_q <= 1'b0;
`endif
        end else if (state == STREAM && bus.flush) begin
            shreg <= '0;
            idx_q <= '0;
        end else if (load) begin
            shreg <= bus.in_data;
            len_q <= len_eff;
            idx_q <= '0;
`ifdef KECCAK_SER_BYTE_SWAP_EN
            swap_q <= swap_bytes;
`endif
        end else if (beat) begin
            if (last) begin
                shreg <= '0;
                idx_q <= '0;
            end else begin
                shreg <= shreg << OUT_W;
                idx_q <= idx_q + CW'(1);
            end
        end
    end

    // The current word always sits in the top slice of the shift register.
    always_comb begin
        word_raw = shreg[IN_W-1 -: OUT_W];
`ifdef KECCAK_SER_BYTE_SWAP_EN
        word_swapped = '0;
        for (int b = 0; b < OUT_W / 8; b++) begin
            word_swapped[b*8 +: 8] = word_raw[OUT_W-8-b*8 +: 8];
        end
        bus.out_data = swap_q ? word_swapped : word_raw;
`else
        bus.out_data = word_raw;
`endif
    end

endmodule

// File: tb/tb_keccak_word_serializer.sv
// Directed plus randomized bench for keccak_word_serializer against a slice-based word model.
// Build with KECCAK_SER_BYTE_SWAP_EN defined to also exercise the byte-swap path.
module tb_keccak_word_serializer;
    localparam int IN_W  = 512;
    localparam int OUT_W = 32;
    localparam int N     = IN_W / OUT_W;
    localparam int CW    = $clog2(N) + 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;
`ifdef KECCAK_SER_BYTE_SWAP_EN
    logic swap_bytes = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    logic [OUT_W-1:0] exp_q[$];

    logic [IN_W-1:0] pat;
    logic [IN_W-1:0] ones;
    logic [IN_W-1:0] rnd;

    always #5 clk = ~clk;

    keccak_word_serializer_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    keccak_word_serializer #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef KECCAK_SER_BYTE_SWAP_EN
        .swap_bytes(swap_bytes),
`endif
        .bus       (bus)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference: the words a consumer should see, taken straight from the block by position.
    task automatic buildExpected(input logic [IN_W-1:0] data, input int len, input bit swap);
        int L;
        logic [OUT_W-1:0] w;
        logic [OUT_W-1:0] ws;
        L = (len == 0 || len > N) ? N : len;
        exp_q.delete();
        for (int k = 0; k < L; k++) begin
            w  = OUT_W'(data >> ((N - 1 - k) * OUT_W));
            ws = {<<8{w}};
            exp_q.push_back(swap ? ws : w);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge where word 0 should be visible.
    task automatic applyStimulus(input logic [IN_W-1:0] data, input int len, input bit swap);
        bus.in_data  = data;
        bus.in_len   = CW'(len);
        bus.in_valid = 1'b1;
`ifdef KECCAK_SER_BYTE_SWAP_EN
        swap_bytes = swap;
`endif
        buildExpected(data, len, swap);
        #1 checkOutput("load_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready.
    task automatic drainBlock(input int mode, input bit keep_valid, input bit no_gap, input string name);
        int k;
        int cyc;
        k   = 0;
        cyc = 0;
        while (k < exp_q.size() && cyc < 500) begin
            if (!keep_valid) bus.in_valid = 1'b0;
            case (mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (bus.out_valid) begin
                checkOutput({name, "_data"}, 64'(bus.out_data), 64'(exp_q[k]));
                checkOutput({name, "_idx"}, 64'(bus.out_idx), 64'(k));
                checkOutput({name, "_last"}, 64'(bus.out_last), 64'(k == exp_q.size() - 1));
                checkOutput({name, "_busy"}, 64'(bus.busy), 64'd1);
                if (bus.out_ready) k++;
            end else if (no_gap) begin
                checkOutput({name, "_gap"}, 64'(bus.out_valid), 64'd1);
            end
            cyc++;
            @(negedge clk);
        end
        checkOutput({name, "_beats"}, 64'(k), 64'(exp_q.size()));
    endtask

    task automatic checkIdle(input string name);
        #1;
        checkOutput({name, "_valid"}, 64'(bus.out_valid), 64'd0);
        checkOutput({name, "_busy"}, 64'(bus.busy), 64'd0);
        checkOutput({name, "_idx"}, 64'(bus.out_idx), 64'd0);
        checkOutput({name, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit sw;
        int len;

        for (int i = 0; i < 32; i++) pat[IN_W-1-16*i -: 16] = 16'(i % 16) * 16'h1111;
        ones = '1;

        bus.in_data   = '0;
        bus.in_len    = '0;
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        reset         = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_last", 64'(bus.out_last), 64'd0);
        checkOutput("rst_data", 64'(bus.out_data), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        checkIdle("rst_idle");

        // Full block, consumer always ready.
        $display("[TB] full stream");
        applyStimulus(pat, 0, 1'b0);
        #1 checkOutput("stream_word0", 64'(bus.out_data), 64'h0000_1111);
        drainBlock(0, 1'b0, 1'b1, "stream");
        checkIdle("stream_idle");

        $display("[TB] backpressure 1,0,0,1");
        applyStimulus(pat, 0, 1'b0);
        drainBlock(1, 1'b0, 1'b0, "bp");
        checkIdle("bp_idle");

        $display("[TB] short and clamped lengths");
        applyStimulus(pat, 3, 1'b0);
        drainBlock(0, 1'b0, 1'b1, "len3");
        checkIdle("len3_idle");
        applyStimulus(pat, 20, 1'b0);
        drainBlock(0, 1'b0, 1'b1, "len20");
        checkIdle("len20_idle");

        // Second block waits with in_valid high and must land on the first block's last beat.
        $display("[TB] back-to-back");
        applyStimulus(pat, 0, 1'b0);
        bus.in_data  = ones;
        bus.in_len   = '0;
        bus.in_valid = 1'b1;
        drainBlock(0, 1'b1, 1'b1, "b2b_a");
        bus.in_valid = 1'b0;
        #1 checkOutput("b2b_word0", 64'(bus.out_data), 64'hFFFF_FFFF);
        buildExpected(ones, 0, 1'b0);
        drainBlock(0, 1'b0, 1'b1, "b2b_b");
        checkIdle("b2b_idle");

        $display("[TB] flush at idx 5");
        applyStimulus(pat, 0, 1'b0);
        bus.out_ready = 1'b1;
        repeat (5) @(negedge clk);
        #1 checkOutput("flush_idx5", 64'(bus.out_idx), 64'd5);
        checkOutput("flush_data5", 64'(bus.out_data), 64'(exp_q[5]));
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = ones;
        #1 checkOutput("flush_in_ready", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        checkIdle("flush_idle");

        $display("[TB] async reset mid-stream");
        applyStimulus(pat, 0, 1'b0);
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("arst_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("arst_data", 64'(bus.out_data), 64'd0);
        checkOutput("arst_last", 64'(bus.out_last), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        checkIdle("arst_idle");
        applyStimulus(pat, 0, 1'b0);
        drainBlock(0, 1'b0, 1'b1, "post_rst");
        checkIdle("post_rst_idle");

`ifdef KECCAK_SER_BYTE_SWAP_EN
        $display("[TB] byte swap");
        rnd = pat;
        rnd[IN_W-1 -: 32] = 32'h0123_4567;
        applyStimulus(rnd, 4, 1'b1);
        #1 checkOutput("swap1_word0", 64'(bus.out_data), 64'h6745_2301);
        drainBlock(0, 1'b0, 1'b1, "swap1");
        checkIdle("swap1_idle");
        applyStimulus(rnd, 4, 1'b0);
        #1 checkOutput("swap0_word0", 64'(bus.out_data), 64'h0123_4567);
        drainBlock(0, 1'b0, 1'b1, "swap0");
        checkIdle("swap0_idle");
`endif

        $display("[TB] random blocks");
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < N; i++) rnd[i*OUT_W +: OUT_W] = $urandom();
            len = $urandom_range(0, 20);
`ifdef KECCAK_SER_BYTE_SWAP_EN
            sw = 1'($urandom_range(0, 1));
`else
            sw = 1'b0;
`endif
            applyStimulus(rnd, len, sw);
            drainBlock(2, 1'b0, 1'b0, "rand");
            checkIdle("rand_idle");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
